multiply_unit: RTL

Iterative 32×32 multiplier in the execute stage, directly downstream of the register bank. It consumes the two read-port operands plus an accumulator operand, and computes MUL, MLA, UMULL or SMULL with a shift-add datapath at one bit per cycle. It returns results through the register bank's single write port, issuing the low word and then, for long forms, the high word on consecutive cycles. A start/ready handshake stalls issue while it is busy.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/multiply_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the iterative multiplier.
//   mulOp_t    : operation encoding carried on the op port
//   mulState_t : multiplier FSM states
//   DATA_WIDTH, PC_ADDR, CALC_CYCLES : datapath width, r15 address, shift-add steps
package mul_pkg;

   localparam int         DATA_WIDTH  = 32;
   localparam logic [3:0] PC_ADDR     = 4'hF;
   localparam int         CALC_CYCLES = 32;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MLA   = 2'b01,
      OP_UMULL = 2'b10,
      OP_SMULL = 2'b11
   } mulOp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_WB_LO,
      ST_WB_HI
   } mulState_t;

endpackage

// File: rtl/multiply_unit.sv
// multiply_unit: iterative 32x32 shift-add multiplier (MUL, MLA, UMULL, SMULL).
// One multiplier bit is retired per cycle. Results go out through the register
// bank's single write port: low word first, then the high word for long forms.
//   clk, resetN         : clock, asynchronous active-low reset
//   start / ready, busy : issue handshake; ready only in IDLE, busy = !ready
//   op, opA, opB, opC   : operation, Rm, Rs, accumulator Rn (MLA only)
//   destLo, destHi      : RdLo (or Rd), RdHi (long forms only)
//   setFlags, flush     : S bit, synchronous abort
//   wbEnable/Address/Data : register bank write port
//   flagN, flagZ, flagsValid : result flags, valid on the flagsValid pulse
module multiply_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  start,
   output logic                  ready,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   input  logic [DATA_WIDTH-1:0] opC,
   input  logic [ADDR_WIDTH-1:0] destLo,
   input  logic [ADDR_WIDTH-1:0] destHi,
   input  logic                  setFlags,
   input  logic                  flush,
   output logic                  wbEnable,
   output logic [ADDR_WIDTH-1:0] wbAddress,
   output logic [DATA_WIDTH-1:0] wbData,
   output logic                  flagN,
   output logic                  flagZ,
   output logic                  flagsValid,
   output logic                  busy
);

   import mul_pkg::*;

   localparam int                  PW     = 2 * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_A = ADDR_WIDTH'(PC_ADDR);
   localparam logic [4:0]          LAST_STEP = 5'(CALC_CYCLES - 1);

   mulState_t             state;
   mulOp_t                opR;
   logic [ADDR_WIDTH-1:0] destLoR;
   logic [ADDR_WIDTH-1:0] destHiR;
   logic                  setFlagsR;
   logic [DATA_WIDTH-1:0] accR;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic                  negR;
   logic [PW-1:0]         product;
   logic [4:0]            count;
   logic                  wbEnR;
   logic                  flagsValidR;

   logic [DATA_WIDTH-1:0] absA;
   logic [DATA_WIDTH-1:0] absB;
   logic [PW-1:0]         fixed;
   logic                  isLong;
   logic                  accept;
   logic                  wbLoFlush;

   assign ready  = (state == ST_IDLE);
   assign busy   = ~ready;
   assign accept = start & ready & ~flush;
   assign isLong = (opR == OP_UMULL) || (opR == OP_SMULL);

   // flush during WB_LO must kill the write already presented this cycle,
   // so the registered strobes are gated combinationally.
   assign wbLoFlush  = flush & (state == ST_WB_LO);
   assign wbEnable   = wbEnR & ~wbLoFlush;
   assign flagsValid = flagsValidR & ~wbLoFlush;

   // Magnitudes for SMULL; -0x80000000 wraps to 0x80000000, which is the
   // correct unsigned magnitude.
   always_comb begin
      absA = opA[DATA_WIDTH-1] ? -opA : opA;
      absB = opB[DATA_WIDTH-1] ? -opB : opB;
   end

   // Sign correction and accumulate applied in the FIX cycle.
   always_comb begin
      fixed = negR ? -product : product;
      if (opR == OP_MLA)
         fixed[DATA_WIDTH-1:0] = fixed[DATA_WIDTH-1:0] + accR;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= ST_IDLE;
         opR         <= OP_MUL;
         destLoR     <= '0;
         destHiR     <= '0;
         setFlagsR   <= 1'b0;
         accR        <= '0;
         mcand       <= '0;
         mplier      <= '0;
         negR        <= 1'b0;
         product     <= '0;
         count       <= '0;
         wbEnR       <= 1'b0;
         wbAddress   <= '0;
         wbData      <= '0;
         flagN       <= 1'b0;
         flagZ       <= 1'b0;
         flagsValidR <= 1'b0;
      end else begin
         // Write-port and flag registers are only non-zero for one cycle.
         wbEnR       <= 1'b0;
         wbAddress   <= '0;
         wbData      <= '0;
         flagN       <= 1'b0;
         flagZ       <= 1'b0;
         flagsValidR <= 1'b0;

         if (flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     opR       <= mulOp_t'(op);
                     destLoR   <= destLo;
                     destHiR   <= destHi;
                     setFlagsR <= setFlags;
                     accR      <= opC;
                     if (mulOp_t'(op) == OP_SMULL) begin
                        mcand  <= absA;
                        mplier <= absB;
                        negR   <= opA[DATA_WIDTH-1] ^ opB[DATA_WIDTH-1];
                     end else begin
                        mcand  <= opA;
                        mplier <= opB;
                        negR   <= 1'b0;
                     end
                     product <= '0;
                     count   <= '0;
                     state   <= ST_CALC;
                  end
               end

               ST_CALC: begin
                  if (mplier[0])
                     product <= product + ({{DATA_WIDTH{1'b0}}, mcand} << count);
                  mplier <= mplier >> 1;
                  count  <= count + 5'd1;
                  if (count == LAST_STEP)
                     state <= ST_FIX;
               end

               ST_FIX: begin
                  // Present the low-word write from the corrected product so
                  // it is registered on entry to WB_LO.
                  product     <= fixed;
                  wbEnR       <= (destLoR != PC_A);
                  wbAddress   <= destLoR;
                  wbData      <= fixed[DATA_WIDTH-1:0];
                  flagsValidR <= setFlagsR;
                  if (isLong) begin
                     flagN <= fixed[PW-1];
                     flagZ <= (fixed == '0);
                  end else begin
                     flagN <= fixed[DATA_WIDTH-1];
                     flagZ <= (fixed[DATA_WIDTH-1:0] == '0);
                  end
                  state <= ST_WB_LO;
               end

               ST_WB_LO: begin
                  if (isLong) begin
                     wbEnR     <= (destHiR != PC_A);
                     wbAddress <= destHiR;
                     wbData    <= product[PW-1:DATA_WIDTH];
                     state     <= ST_WB_HI;
                  end else begin
                     state <= ST_IDLE;
                  end
               end

               ST_WB_HI: state <= ST_IDLE;

               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
